// File: rtl/bias_relu_stage.sv
`default_nettype none
// ---- bias_relu_stage: per-lane bias add, 18-bit saturation and optional ReLU in a 2-stage pipe
// ---- Rev 1.0
module bias_relu_stage #(
  parameter int N_adder_tree = 16,
  parameter int PIX_PER_MAP  = 784,
  parameter int RELU_EN      = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N_adder_tree*18-1:0] in_data,
  input  logic [N_adder_tree*18-1:0] bias,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N_adder_tree*18-1:0] out_data,
  output logic                       out_last,
  output logic                       sat_flag
);

  localparam int        c_W        = N_adder_tree * 18;
  localparam int        c_SW       = N_adder_tree * 19;
  localparam logic [9:0] c_LAST_PIX = 10'(PIX_PER_MAP - 1);

  logic                    w_en;
  logic                    w_xfer;
  logic [c_SW-1:0]         w_sum;
  logic [c_W-1:0]          w_res;
  logic [N_adder_tree-1:0] w_clip;

  logic                    r_s1_valid;
  logic [c_SW-1:0]         r_s1_sum;
  logic                    r_out_valid;
  logic [c_W-1:0]          r_out_data;
  logic [9:0]              r_pix_cnt;
  logic                    r_sat;

  // The whole pipe advances together; a stalled S2 also freezes S1 (no skid buffer).
  assign w_en   = out_ready | ~r_out_valid;
  assign w_xfer = r_out_valid & out_ready;

  generate
    for (genvar gi = 0; gi < N_adder_tree; gi++) begin : g_lane
      logic [18:0] w_s;
      logic [17:0] w_sat;

      assign w_sum[19*gi +: 19] = {in_data[18*gi+17], in_data[18*gi +: 18]}
                                + {bias[18*gi+17], bias[18*gi +: 18]};
      assign w_s        = r_s1_sum[19*gi +: 19];
      assign w_clip[gi] = w_s[18] ^ w_s[17];
      assign w_sat      = w_clip[gi] ? (w_s[18] ? 18'h20000 : 18'h1FFFF) : w_s[17:0];
      assign w_res[18*gi +: 18] = ((RELU_EN != 0) && w_sat[17]) ? 18'd0 : w_sat;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (w_en) begin
      r_s1_sum <= w_sum;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_pix_cnt   <= '0;
      r_sat       <= 1'b0;
    end else begin
      if (w_en) begin
        r_s1_valid  <= in_valid;
        r_out_valid <= r_s1_valid;
        r_out_data  <= w_res;
        if (r_s1_valid && (|w_clip)) begin
          r_sat <= 1'b1;
        end
      end
      if (w_xfer) begin
        r_pix_cnt <= (r_pix_cnt == c_LAST_PIX) ? 10'd0 : r_pix_cnt + 10'd1;
      end
    end
  end

  assign in_ready  = w_en;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_valid & (r_pix_cnt == c_LAST_PIX);
  assign sat_flag  = r_sat;

endmodule
`default_nettype wire

// File: doc/bias_relu_stage.md
BIAS_RELU_STAGE -- requirements
Module: bias_relu_stage

Interface
REQ-001 The block SHALL have parameter N_adder_tree, default 16, giving the number of parallel lanes.
REQ-002 The block SHALL have parameter PIX_PER_MAP, default 784, giving the number of output vectors per feature map (28x28).
REQ-003 The block SHALL have parameter RELU_EN, default 1; 1 applies ReLU and 0 bypasses it.
REQ-004 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port in_valid, input, 1 bit: in_data holds a valid accumulator vector.
REQ-007 Port in_ready, output, 1 bit: the block accepts in_data this cycle.
REQ-008 Port in_data, input, N_adder_tree*18 bits: lane i occupies bits [18*(i+1)-1:18*i], signed two's complement, same fixed-point format as the bias.
REQ-009 Port bias, input, N_adder_tree*18 bits: per-lane signed bias constants, same lane packing, driven by the layer's BIAS bank and static during operation.
REQ-010 Port out_valid, output, 1 bit: out_data holds a valid result vector.
REQ-011 Port out_ready, input, 1 bit: the downstream stage accepts out_data this cycle.
REQ-012 Port out_data, output, N_adder_tree*18 bits: per-lane result, same packing.
REQ-013 Port out_last, output, 1 bit: marks the final vector of a feature map.
REQ-014 Port sat_flag, output, 1 bit: sticky flag, set when any lane has saturated since reset.

Function
REQ-015 The block SHALL be a two-stage pipeline.
- S1 registers the per-lane 19-bit sums in_data[i] + bias[i], sign-extended.
- S2 registers the saturated, optionally ReLU'd 18-bit results and drives out_data.
REQ-016 The pipeline enable SHALL be en = out_ready OR NOT out_valid, and in_ready SHALL equal en combinationally.
REQ-017 An input transfer SHALL occur when in_valid AND in_ready are both high.
REQ-018 When en is high, S1 SHALL load the sum and a valid bit equal to in_valid; S2 SHALL load from S1.
REQ-019 When en is low, S1 and S2 SHALL hold their contents, valid bits included.
REQ-020 Latency from an accepted input to out_valid SHALL be exactly 2 cycles when out_ready is held high.
REQ-021 Sustained throughput SHALL be one vector per cycle.
REQ-022 out_data and out_valid SHALL remain stable while out_valid=1 and out_ready=0.
REQ-023 Each 19-bit sum SHALL saturate to the range [-131072, +131071]:
- above +131071 -> 131071;
- below -131072 -> -131072.
REQ-024 With RELU_EN=1, any negative saturated result SHALL output 0; with RELU_EN=0, the saturated value SHALL pass unchanged.
REQ-025 sat_flag SHALL be set in the cycle S2 loads a valid vector in which any lane clipped; it SHALL stay set until reset.
REQ-026 A 10-bit pix_cnt SHALL increment on every output transfer (out_valid AND out_ready).
REQ-027 out_last SHALL equal out_valid AND (pix_cnt == PIX_PER_MAP-1).
REQ-028 On the transfer with pix_cnt == PIX_PER_MAP-1, pix_cnt SHALL wrap to 0.
REQ-029 Data with the valid bit low SHALL NOT affect pix_cnt or sat_flag.
REQ-030 When S2 stalls while S1 is empty, in_ready SHALL be low; a one-bubble loss is accepted and there SHALL be no skid buffer.

Reset
REQ-031 Assertion of rst_n low SHALL asynchronously clear:
- both valid bits;
- out_data;
- pix_cnt;
- sat_flag;
- out_last.
REQ-032 Reset values: out_valid=0, out_last=0, sat_flag=0, out_data=0.
REQ-033 in_ready SHALL read 1 during reset because the pipeline is empty.
REQ-034 Vectors in flight at reset SHALL be discarded, and the first transfer after release SHALL count as pix_cnt 0.

Verification
REQ-035 Basic add: lane0 bias=508, in=100, out_ready=1 -> lane0 out=608 two cycles later; out_valid high for exactly one cycle.
REQ-036 ReLU: lane1 bias=-820, in=500 -> lane1 out=0 with RELU_EN=1; out=-320 (18'h3FEC0) with RELU_EN=0.
REQ-037 Saturation:
- lane0 bias=508, in=131000 -> out=131071 and sat_flag=1, which stays 1 after further normal vectors.
- With RELU_EN=0, lane1 in=-131072 -> out=-131072.
REQ-038 Back-pressure: stream 8 vectors with out_ready toggling 1010... -> all 8 delivered in order, none duplicated or dropped, data stable while stalled.
REQ-039 Map boundary: stream 785 vectors -> out_last high only on vector 784; vector 785 has out_last=0 and pix_cnt wraps.
REQ-040 Mid-stream reset: assert rst_n low with 2 vectors in flight -> out_valid drops immediately, no stale vector appears after release, and the next map's 784th vector asserts out_last.
